// File: rtl/gcd_pkg.sv
// gcd_pkg -- shared types and constants for the Euclid GCD controller.
//   gcd_state_e : controller FSM states
//   MOD_W       : datapath width of the sibling mod unit
//   DATA_W_DEF  : default operand width (kept at 31 so mod operands have bit 31 = 0)
//   ITER_W_DEF  : default iteration counter width
package gcd_pkg;

  localparam int MOD_W      = 32;
  localparam int DATA_W_DEF = 31;
  localparam int ITER_W_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    DONE
  } gcd_state_e;

endpackage

// File: rtl/gcd_euclid_ctrl.sv
// gcd_euclid_ctrl -- sequencing controller for Euclid's GCD algorithm.
// Accepts an operand pair, repeatedly drives the sibling 32-bit mod unit with
// (a, b) until b == 0, then returns gcd = a and the number of remainder/swap
// steps taken.
//
// Optional build macro: GCD_SWAP_SHORTCUT_EN
//   defined   : when a < b in CHECK the pair is swapped locally in one cycle
//   undefined : every step goes through the mod unit (a % b == a swaps too)
//   Results are identical either way; only the cycle count differs.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   in_valid_i         operand pair valid
//   in_ready_o         controller can accept (IDLE only)
//   in_a_i, in_b_i     operands (DATA_W)
//   out_valid_o        result valid, held until out_ready_i
//   out_ready_i        consumer accepts result
//   out_gcd_o          gcd(in_a, in_b)
//   out_iters_o        remainder/swap step count (saturating)
//   busy_o             high in every state except IDLE
//   mod_run_o          one-cycle start pulse to the mod unit
//   mod_a_o, mod_b_o   zero-extended a/b registers
//   mod_result_i       remainder from the mod unit
//   mod_ready_i        mod unit done (level)
//
// States:
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   CHECK | b == 0 -> DONE; a < b -> local swap (shortcut build); else ISSUE
//   ISSUE | mod_run pulse; mod_ready ignored (may be stale from last op)
//   WAIT  | waiting for mod_ready, then a <= b, b <= remainder
//   DONE  | result presented, held until out_ready
module gcd_euclid_ctrl
  import gcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,  // must stay <= 31
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_gcd_o,
  output logic [ITER_W-1:0] out_iters_o,
  output logic              busy_o,
  output logic              mod_run_o,
  output logic [MOD_W-1:0]  mod_a_o,
  output logic [MOD_W-1:0]  mod_b_o,
  input  logic [MOD_W-1:0]  mod_result_i,
  input  logic              mod_ready_i
);

  gcd_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [ITER_W-1:0] iters_inc;

  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              mod_run_q;
  logic [DATA_W-1:0] out_gcd_q;
  logic [ITER_W-1:0] out_iters_q;

  // Remainder is always < b, so the bits above DATA_W are zero by construction.
  logic              unused_mod_hi;
  assign unused_mod_hi = |mod_result_i[MOD_W-1:DATA_W];

  assign iters_inc = (&iters_q) ? iters_q : iters_q + ITER_W'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    iters_d = iters_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = in_a_i;
          b_d     = in_b_i;
          iters_d = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // b == 0 must be caught here: the mod unit never finishes a divide by 0.
        if (b_q == '0) begin
          state_d = DONE;
        end
`ifdef GCD_SWAP_SHORTCUT_EN
        else if (a_q < b_q) begin
          a_d     = b_q;
          b_d     = a_q;
          iters_d = iters_inc;
        end
`endif
        else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mod_ready_i) begin
          a_d     = b_q;
          b_d     = mod_result_i[DATA_W-1:0];
          iters_d = iters_inc;
          state_d = CHECK;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      iters_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mod_run_q   <= 1'b0;
      out_gcd_q   <= '0;
      out_iters_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      iters_q     <= iters_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      mod_run_q   <= (state_d == ISSUE);
      out_gcd_q   <= (state_d == DONE) ? a_d : '0;
      out_iters_q <= (state_d == DONE) ? iters_d : '0;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign mod_run_o   = mod_run_q;
  assign out_gcd_o   = out_gcd_q;
  assign out_iters_o = out_iters_q;

  assign mod_a_o = {{(MOD_W-DATA_W){1'b0}}, a_q};
  assign mod_b_o = {{(MOD_W-DATA_W){1'b0}}, b_q};

endmodule

// File: tb/tb_gcd_euclid_ctrl.sv
module tb_gcd_euclid_ctrl;
  import gcd_pkg::*;

  localparam int DW = 31;
  localparam int IW = 6;
  localparam int TMO = 3000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_gcd;
  logic [IW-1:0] out_iters;
  logic          busy;
  logic          mod_run;
  logic [31:0]   mod_a, mod_b, mod_result;
  logic          mod_ready;

  gcd_euclid_ctrl #(.DATA_W(DW), .ITER_W(IW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_gcd_o    (out_gcd),
    .out_iters_o  (out_iters),
    .busy_o       (busy),
    .mod_run_o    (mod_run),
    .mod_a_o      (mod_a),
    .mod_b_o      (mod_b),
    .mod_result_i (mod_result),
    .mod_ready_i  (mod_ready)
  );

  // behavioural mod unit: variable latency, ready level stays high until next run
  logic [31:0] m_a, m_b;
  logic [2:0]  m_cnt;
  logic        m_busy;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mod_ready  <= 1'b1;
      mod_result <= '0;
      m_busy     <= 1'b0;
      m_cnt      <= '0;
      m_a        <= '0;
      m_b        <= '0;
    end else if (mod_run) begin
      mod_ready <= 1'b0;
      m_busy    <= 1'b1;
      m_cnt     <= 3'($urandom_range(0, 4));
      m_a       <= mod_a;
      m_b       <= mod_b;
    end else if (m_busy) begin
      if (m_cnt != 0) m_cnt <= m_cnt - 3'd1;
      else if (m_b != 0) begin
        mod_result <= m_a % m_b;
        mod_ready  <= 1'b1;
        m_busy     <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [DW-1:0] g;
    logic [IW-1:0] it;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] mod_log[$];
  logic [63:0] ep[3];
  int          n_run = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void gcd_ref(input logic [DW-1:0] ai, input logic [DW-1:0] bi,
                                  output logic [DW-1:0] g, output logic [IW-1:0] it);
    longint unsigned a, b, t;
    a = 64'(ai);
    b = 64'(bi);
    it = '0;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
      if (it != {IW{1'b1}}) it = it + IW'(1);
    end
    g = DW'(a);
  endfunction

  // monitors sample on the falling edge, inputs change at posedge + 2
  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("out_gcd", 64'(out_gcd), 64'(mon_e.g));
          chk("out_iters", 64'(out_iters), 64'(mon_e.it));
        end
      end
      if (mod_run) begin
        n_run++;
        mod_log.push_back({mod_a, mod_b});
        chk("mod_b_nonzero", 64'(mod_b != 0), 64'd1);
        chk("mod_a_msb", 64'(mod_a[31]), 64'd0);
      end
      if (out_valid) chk("in_ready_in_done", 64'(in_ready), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] g;
    logic [IW-1:0] it;
    gcd_ref(a, b, g, it);
    sb.push_back('{g: g, it: it});
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    push_exp(a, b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < TMO) begin tick(); n++; end
    chk("accept_in_time", 64'(n < TMO), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < TMO) begin tick(); n++; end
    chk("result_in_time", 64'(n < TMO), 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    send(a, b);
    wait_valid();
    drain();
  endtask

  initial begin
    int r0, n;
    logic [DW-1:0] g;
    logic [IW-1:0] it;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mod_run", 64'(mod_run), 64'd0);
    chk("rst_out_gcd", 64'(out_gcd), 64'd0);
    chk("rst_out_iters", 64'(out_iters), 64'd0);
    resetn = 1'b1;
    tick();

    // (48,18): three mod calls with known operands
    ep[0] = {32'd48, 32'd18};
    ep[1] = {32'd18, 32'd12};
    ep[2] = {32'd12, 32'd6};
    mod_log.delete();
    do_pair(DW'(48), DW'(18));
    chk("runs_48_18", 64'(mod_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < mod_log.size(); i++) chk("run_operands", mod_log[i], ep[i]);

    // (18,48): swap step via shortcut or via mod call
    r0 = n_run;
    do_pair(DW'(18), DW'(48));
`ifdef GCD_SWAP_SHORTCUT_EN
    chk("runs_18_48", 64'(n_run - r0), 64'd3);
`else
    chk("runs_18_48", 64'(n_run - r0), 64'd4);
`endif

    // zero operands
    r0 = n_run;
    do_pair(DW'(0), DW'(0));
    do_pair(DW'(7), DW'(0));
    chk("runs_zero_b", 64'(n_run - r0), 64'd0);
    r0 = n_run;
    do_pair(DW'(0), DW'(9));
`ifdef GCD_SWAP_SHORTCUT_EN
    chk("runs_0_9", 64'(n_run - r0), 64'd0);
`else
    chk("runs_0_9", 64'(n_run - r0), 64'd1);
`endif

    // full-width operands and a long Fibonacci chain
    do_pair(DW'(32'h7FFF_FFFF), DW'(1));
    do_pair(DW'(1), DW'(32'h7FFF_FFFF));
    do_pair(DW'(1836311903), DW'(1134903170));

    for (int i = 0; i < 6; i++) do_pair(DW'($urandom_range(0, 5000)), DW'($urandom_range(0, 5000)));

    // result held in DONE while a second pair waits
    send(DW'(48), DW'(18));
    wait_valid();
    gcd_ref(DW'(48), DW'(18), g, it);
    push_exp(DW'(35), DW'(14));
    in_valid = 1'b1;
    in_a = DW'(35);
    in_b = DW'(14);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_gcd", 64'(out_gcd), 64'(g));
      chk("hold_iters", 64'(out_iters), 64'(it));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    drain();
    chk("second_accept_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("second_busy", 64'(busy), 64'd1);
    wait_valid();
    drain();

    // reset while waiting on the mod unit
    send(DW'(48), DW'(18));
    n = 0;
    while (!mod_run && n < TMO) begin tick(); n++; end
    chk("issue_in_time", 64'(n < TMO), 64'd1);
    tick();
    chk("in_wait_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_mod_run", 64'(mod_run), 64'd0);
    sb.delete();
    tick();
    tick();
    resetn = 1'b1;
    tick();
    do_pair(DW'(35), DW'(14));

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
